// File: rtl/hnf_link_txreq_send.sv
// HN-F TXREQ link transmitter: queues MSHR REQ flits and launches them onto the link against partner L-credits.
// Latency: a flit pushed in cycle N is earliest on the link in cycle N+2; FLITPEND leads FLITV by one cycle.
// Backpressure: ready = !fifo_full (independent of valid); queued flits wait while the L-credit count is zero.

`ifndef CHIE_REQ_FLIT_WIDTH
`define CHIE_REQ_FLIT_WIDTH 128
`endif

module hnf_link_txreq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module hnf_link_txreq_send #(
    parameter int FIFO_DEPTH = 4,
    parameter int LCRD_MAX   = 15,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mshr_txreq_valid_sx,
    input  logic [`CHIE_REQ_FLIT_WIDTH-1:0] mshr_txreq_flit_sx,
    output logic                            txreq_mshr_ready_sx,
    input  logic                            txreqlcrdv,
    output logic                            txreqflitpend,
    output logic                            txreqflitv,
    output logic [`CHIE_REQ_FLIT_WIDTH-1:0] txreqflit,
    output logic [CNT_WIDTH-1:0]            txreq_crd_cnt_q,
    output logic                            txreq_idle,
    output logic                            txreq_crd_ovf_err_q
);
    localparam int FW  = `CHIE_REQ_FLIT_WIDTH;
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    logic [FCW-1:0]       fifo_cnt;
    logic [FCW-1:0]       fifo_cnt_nxt;
    logic [FW-1:0]        fifo_head;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 send_s0;
    logic [CNT_WIDTH-1:0] crd_nxt;
    logic                 ovf_set;

    assign fifo_empty          = (fifo_cnt == '0);
    assign fifo_full           = (fifo_cnt == FCW'(FIFO_DEPTH));
    assign txreq_mshr_ready_sx = !fifo_full;
    assign push                = mshr_txreq_valid_sx && txreq_mshr_ready_sx;
    assign send_s0             = !fifo_empty && (txreq_crd_cnt_q != '0);
    assign fifo_cnt_nxt        = fifo_cnt + FCW'(push) - FCW'(send_s0);

    hnf_link_txreq_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH),
        .CW    (FCW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (mshr_txreq_flit_sx),
        .pop      (send_s0),
        .head_dat (fifo_head),
        .count    (fifo_cnt)
    );

    // Grant and consume in the same cycle cancel; a grant at LCRD_MAX is a partner protocol error.
    always_comb begin
        crd_nxt = txreq_crd_cnt_q;
        ovf_set = 1'b0;
        case ({txreqlcrdv, send_s0})
            2'b10: begin
                if (txreq_crd_cnt_q == CNT_WIDTH'(LCRD_MAX)) ovf_set = 1'b1;
                else                                         crd_nxt = txreq_crd_cnt_q + 1'b1;
            end
            2'b01:   crd_nxt = txreq_crd_cnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txreq_crd_cnt_q     <= '0;
            txreq_crd_ovf_err_q <= 1'b0;
            txreqflitv          <= 1'b0;
            txreqflit           <= '0;
            txreqflitpend       <= 1'b0;
        end else begin
            txreq_crd_cnt_q     <= crd_nxt;
            txreq_crd_ovf_err_q <= txreq_crd_ovf_err_q | ovf_set;
            txreqflitv          <= send_s0;
            txreqflit           <= send_s0 ? fifo_head : '0;
            txreqflitpend       <= (fifo_cnt_nxt != '0);
        end
    end

    assign txreq_idle = fifo_empty && !txreqflitv;

`ifdef DISPLAY_FATAL
    logic sent_with_crd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sent_with_crd_q <= 1'b0;
        else     sent_with_crd_q <= send_s0 && (txreq_crd_cnt_q != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst && txreqflitv && !sent_with_crd_q)
            $fatal(1, "hnf_link_txreq_send: flit launched without an L-credit");
    end
`endif
endmodule

// File: tb/tb_hnf_link_txreq_send.sv
// Directed bench for hnf_link_txreq_send: credit accounting, FIFO order/backpressure, pend timing, overflow, reset.
`ifndef CHIE_REQ_FLIT_WIDTH
`define CHIE_REQ_FLIT_WIDTH 128
`endif

module tb_hnf_link_txreq_send;
    localparam int FW = `CHIE_REQ_FLIT_WIDTH;
    localparam logic [6:0] OP_RD = 7'h04;
    localparam logic [6:0] OP_WR = 7'h1D;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [FW-1:0] flit_in;
    logic          ready;
    logic          lcrdv;
    logic          pend;
    logic          flitv;
    logic [FW-1:0] flit_out;
    logic [3:0]    crd_cnt;
    logic          idle;
    logic          ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [FW-1:0] mon_q[$];
    int            mon_cyc[$];

    hnf_link_txreq_send #(
        .FIFO_DEPTH (4),
        .LCRD_MAX   (15),
        .CNT_WIDTH  (4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mshr_txreq_valid_sx (valid),
        .mshr_txreq_flit_sx  (flit_in),
        .txreq_mshr_ready_sx (ready),
        .txreqlcrdv          (lcrdv),
        .txreqflitpend       (pend),
        .txreqflitv          (flitv),
        .txreqflit           (flit_out),
        .txreq_crd_cnt_q     (crd_cnt),
        .txreq_idle          (idle),
        .txreq_crd_ovf_err_q (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && flitv) begin
            mon_q.push_back(flit_out);
            mon_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required < 100000", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] mk(input logic [6:0] op, input logic [11:0] txn);
        logic [FW-1:0] f;
        f              = '0;
        f[11:0]        = txn;
        f[18:12]       = op;
        f[FW-1 -: 8]   = 8'hA5 ^ txn[7:0];
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkf(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expect exactly n flits with txnids base..base+n-1 on consecutive cycles.
    task automatic chk_stream(input string tag, input logic [6:0] op, input int base, input int n);
        chk({tag, "_count"}, 32'(mon_q.size()), 32'(n));
        for (int i = 0; i < n && i < mon_q.size(); i++) begin
            chkf({tag, "_flit"}, mon_q[i], mk(op, 12'(base + i)));
            chk({tag, "_cycle"}, 32'(mon_cyc[i] - mon_cyc[0]), 32'(i));
        end
    endtask

    initial begin
        int idx;
        logic acc;
        rst     = 1'b1;
        valid   = 1'b0;
        flit_in = '0;
        lcrdv   = 1'b0;
        tick;
        tick;
        chk("rst_cnt",   32'(crd_cnt), 32'd0);
        chk("rst_flitv", 32'(flitv),   32'd0);
        chk("rst_pend",  32'(pend),    32'd0);
        chk("rst_idle",  32'(idle),    32'd1);
        chk("rst_ready", 32'(ready),   32'd1);
        chk("rst_ovf",   32'(ovf),     32'd0);
        chkf("rst_flit", flit_out,     '0);
        rst = 1'b0;
        tick;

        // One flit with no credits: pend rises and stays, nothing launches.
        valid   = 1'b1;
        flit_in = mk(OP_RD, 12'h005);
        tick;
        valid   = 1'b0;
        flit_in = '0;
        chk("t1_pend",  32'(pend),    32'd1);
        chk("t1_flitv", 32'(flitv),   32'd0);
        chk("t1_cnt",   32'(crd_cnt), 32'd0);
        chk("t1_idle",  32'(idle),    32'd0);
        tick;
        chk("t1_pend_hold",  32'(pend),  32'd1);
        chk("t1_flitv_hold", 32'(flitv), 32'd0);

        // Single credit releases it.
        lcrdv = 1'b1;
        tick;
        lcrdv = 1'b0;
        chk("t2_cnt1",      32'(crd_cnt), 32'd1);
        chk("t2_flitv_pre", 32'(flitv),   32'd0);
        tick;
        chk("t2_flitv",     32'(flitv),   32'd1);
        chkf("t2_flit",     flit_out,     mk(OP_RD, 12'h005));
        chk("t2_cnt0",      32'(crd_cnt), 32'd0);
        chk("t2_pend_drop", 32'(pend),    32'd0);
        chk("t2_busy",      32'(idle),    32'd0);
        tick;
        chk("t2_idle",      32'(idle),    32'd1);
        chk("t2_flitv_off", 32'(flitv),   32'd0);
        chkf("t2_flit_zero", flit_out,    '0);

        // Fill the FIFO with no credits; ready drops at 4 entries.
        for (int i = 0; i < 4; i++) begin
            valid   = 1'b1;
            flit_in = mk(OP_WR, 12'(16 + i));
            tick;
        end
        chk("t3_ready_full", 32'(ready), 32'd0);
        chk("t3_pend",       32'(pend),  32'd1);
        flit_in = mk(OP_WR, 12'h014);
        tick;
        chk("t3_ready_held",    32'(ready), 32'd0);
        chk("t3_flitv_blocked", 32'(flitv), 32'd0);

        // 15 back-to-back grants while the remaining two flits are offered.
        mon_q.delete();
        mon_cyc.delete();
        idx = 4;
        for (int g = 0; g < 15; g++) begin
            lcrdv = 1'b1;
            if (idx < 6) begin
                valid   = 1'b1;
                flit_in = mk(OP_WR, 12'(16 + idx));
            end else begin
                valid   = 1'b0;
                flit_in = '0;
            end
            acc = valid && ready;
            tick;
            if (acc) idx++;
        end
        lcrdv   = 1'b0;
        valid   = 1'b0;
        flit_in = '0;
        repeat (4) tick;
        chk("t3_accepted", 32'(idx), 32'd6);
        chk_stream("t3", OP_WR, 16, 6);
        chk("t3_cnt9", 32'(crd_cnt), 32'd9);

        // Six more flits without grants consume credits down to 3.
        mon_q.delete();
        mon_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            valid   = 1'b1;
            flit_in = mk(OP_RD, 12'(32 + i));
            tick;
        end
        valid   = 1'b0;
        flit_in = '0;
        repeat (3) tick;
        chk_stream("t4", OP_RD, 32, 6);
        chk("t4_cnt3", 32'(crd_cnt), 32'd3);

        // Sustained traffic with a grant every sending cycle: count holds at 3.
        mon_q.delete();
        mon_cyc.delete();
        valid   = 1'b1;
        flit_in = mk(OP_WR, 12'h030);
        tick;
        for (int i = 1; i < 8; i++) begin
            flit_in = mk(OP_WR, 12'(48 + i));
            lcrdv   = 1'b1;
            chk("t5_ready", 32'(ready), 32'd1);
            tick;
            chk("t5_cnt_hold", 32'(crd_cnt), 32'd3);
        end
        valid   = 1'b0;
        flit_in = '0;
        tick;
        lcrdv = 1'b0;
        chk("t5_cnt_last", 32'(crd_cnt), 32'd3);
        repeat (3) tick;
        chk_stream("t5", OP_WR, 48, 8);
        chk("t5_cnt_end", 32'(crd_cnt), 32'd3);

        // Saturation and sticky overflow.
        lcrdv = 1'b1;
        repeat (12) tick;
        lcrdv = 1'b0;
        chk("t6_cnt15",  32'(crd_cnt), 32'd15);
        chk("t6_no_ovf", 32'(ovf),     32'd0);
        lcrdv = 1'b1;
        tick;
        lcrdv = 1'b0;
        chk("t6_cnt_sat", 32'(crd_cnt), 32'd15);
        chk("t6_ovf",     32'(ovf),     32'd1);
        repeat (3) tick;
        chk("t6_ovf_sticky", 32'(ovf), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t6_ovf_clr", 32'(ovf),     32'd0);
        chk("t6_cnt_clr", 32'(crd_cnt), 32'd0);

        // Reset in the middle of a send discards queue and credits.
        for (int i = 0; i < 3; i++) begin
            valid   = 1'b1;
            flit_in = mk(OP_RD, 12'(64 + i));
            tick;
        end
        valid   = 1'b0;
        flit_in = '0;
        lcrdv   = 1'b1;
        tick;
        tick;
        lcrdv = 1'b0;
        chk("t7_mid_flitv", 32'(flitv),   32'd1);
        chk("t7_mid_cnt",   32'(crd_cnt), 32'd1);
        rst = 1'b1;
        #1;
        chk("t7_rst_cnt",   32'(crd_cnt), 32'd0);
        chk("t7_rst_flitv", 32'(flitv),   32'd0);
        chk("t7_rst_pend",  32'(pend),    32'd0);
        chk("t7_rst_idle",  32'(idle),    32'd1);
        chk("t7_rst_ready", 32'(ready),   32'd1);
        chkf("t7_rst_flit", flit_out,     '0);
        tick;
        rst = 1'b0;
        mon_q.delete();
        mon_cyc.delete();
        repeat (5) tick;
        chk("t7_quiet",      32'(mon_q.size()), 32'd0);
        chk("t7_quiet_cnt",  32'(crd_cnt),      32'd0);
        chk("t7_quiet_idle", 32'(idle),         32'd1);
        valid   = 1'b1;
        flit_in = mk(OP_WR, 12'h050);
        tick;
        valid   = 1'b0;
        flit_in = '0;
        tick;
        chk("t7_no_crd_flitv", 32'(flitv), 32'd0);
        lcrdv = 1'b1;
        tick;
        lcrdv = 1'b0;
        chk("t7_new_cnt", 32'(crd_cnt), 32'd1);
        tick;
        chk("t7_new_flitv", 32'(flitv), 32'd1);
        chkf("t7_new_flit", flit_out,   mk(OP_WR, 12'h050));
        tick;
        chk("t7_total", 32'(mon_q.size()), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
